// File: rtl/vga_ovl_pkg.sv
// Shared constants, types and helpers for the VGA digit overlay.
package vga_ovl_pkg;

    localparam int unsigned FONT_W     = 8;
    localparam int unsigned FONT_H     = 16;
    localparam int unsigned NUM_GLYPHS = 11;
    localparam logic [3:0]  GLYPH_DASH = 4'd10;

    typedef logic [23:0] rgb24_t;

    // Non-decimal codes all render as a dash.
    function automatic logic [3:0] bcd_to_glyph(input logic [3:0] bcd);
        return (bcd > 4'd9) ? GLYPH_DASH : bcd;
    endfunction

endpackage

// File: rtl/vga_glyph_rom.sv
// 11-glyph 8x16 seven-segment style font, registered single-bit read.
module vga_glyph_rom
    import vga_ovl_pkg::*;
(
    input  logic       VGA_CLK,
    input  logic       RST_N,
    input  logic [3:0] glyph,
    input  logic [3:0] row,
    input  logic [2:0] col,
    output logic       pixel
);

    logic [6:0] segs;     // {g, f, e, d, c, b, a}
    logic [7:0] row_bits; // bit n = font column n
    logic       pixel_q;

    always_comb begin
        case (glyph)
            4'd0:    segs = 7'b011_1111;
            4'd1:    segs = 7'b000_0110;
            4'd2:    segs = 7'b101_1011;
            4'd3:    segs = 7'b100_1111;
            4'd4:    segs = 7'b110_0110;
            4'd5:    segs = 7'b110_1101;
            4'd6:    segs = 7'b111_1101;
            4'd7:    segs = 7'b000_0111;
            4'd8:    segs = 7'b111_1111;
            4'd9:    segs = 7'b110_1111;
            4'd10:   segs = 7'b100_0000;
            default: segs = 7'b000_0000;
        endcase
    end

    // Horizontal bars span cols 1-6; vertical bars are two columns wide.
    always_comb begin
        row_bits = 8'h00;
        if (segs[0] && row >= 4'd1 && row <= 4'd2)  row_bits = row_bits | 8'h7E;
        if (segs[1] && row >= 4'd1 && row <= 4'd8)  row_bits = row_bits | 8'h60;
        if (segs[2] && row >= 4'd7 && row <= 4'd14) row_bits = row_bits | 8'h60;
        if (segs[3] && row >= 4'd13 && row <= 4'd14) row_bits = row_bits | 8'h7E;
        if (segs[4] && row >= 4'd7 && row <= 4'd14) row_bits = row_bits | 8'h06;
        if (segs[5] && row >= 4'd1 && row <= 4'd8)  row_bits = row_bits | 8'h06;
        if (segs[6] && row >= 4'd7 && row <= 4'd8)  row_bits = row_bits | 8'h7E;
    end

    always_ff @(posedge VGA_CLK or posedge RST_N) begin
        if (RST_N) pixel_q <= 1'b0;
        else       pixel_q <= row_bits[col];
    end

    assign pixel = pixel_q;

endmodule

// File: rtl/vga_digit_overlay.sv
// Overlays double-buffered BCD digits onto the active VGA area, 2-cycle pipeline.
// Optional per-digit blinking is enabled by defining VGA_OVL_BLINK_EN.
module vga_digit_overlay
    import vga_ovl_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = 1024,
    parameter int unsigned V_ACTIVE   = 768,
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned SCALE_LOG2 = 1,
    parameter int unsigned GAP        = 0,
    parameter int unsigned POS_X      = 448,
    parameter int unsigned POS_Y      = 368,
    parameter rgb24_t      FG_COLOR   = 24'hFFFFFF,
    parameter rgb24_t      BG_COLOR   = 24'h000000,
    parameter int unsigned LZB        = 1
) (
    input  logic                      VGA_CLK,
    input  logic                      RST_N,
    input  logic                      PIX_EN,
    input  logic [4*NUM_DIGITS-1:0]   NUMBER_BCD,
    input  logic [NUM_DIGITS-1:0]     DIGIT_EN,
`ifdef VGA_OVL_BLINK_EN
    input  logic [NUM_DIGITS-1:0]     BLINK_MASK,
`endif
    input  logic                      BCD_LOAD,
    output logic [23:0]               VGA_BUF_RGB,
    output logic                      RGB_VLD,
    output logic                      FRAME_END
);

    localparam int unsigned CELL_W = FONT_W << SCALE_LOG2;
    localparam int unsigned CELL_H = FONT_H << SCALE_LOG2;
    localparam int unsigned PITCH  = CELL_W + GAP;

    function automatic logic [11:0] cell_x0(input int unsigned idx);
        return 12'(POS_X + (NUM_DIGITS - 1 - idx) * PITCH);
    endfunction

    logic [10:0]             x_q, y_q;
    logic                    last_pix;
    logic [4*NUM_DIGITS-1:0] sh_bcd_q, act_bcd_q;
    logic [NUM_DIGITS-1:0]   sh_en_q, act_en_q;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    leading;
    logic [11:0]             px, py, dx, dy;
    logic                    in_rows, hit, hit_show;
    logic [3:0]              hit_bcd, hit_row;
    logic [2:0]              hit_col;
    logic                    s1_vld_q, s1_fe_q, s1_show_q;
    logic [3:0]              s1_glyph_q, s1_row_q;
    logic [2:0]              s1_col_q;
    logic                    s2_vld_q, s2_fe_q, s2_show_q;
    logic                    rom_bit;
`ifdef VGA_OVL_BLINK_EN
    logic [NUM_DIGITS-1:0]   sh_blink_q, act_blink_q;
    logic [5:0]              frame_cnt_q;
`endif

    assign last_pix = PIX_EN && (x_q == 11'(H_ACTIVE - 1)) && (y_q == 11'(V_ACTIVE - 1));

    always_ff @(posedge VGA_CLK or posedge RST_N) begin
        if (RST_N) begin
            x_q <= '0;
            y_q <= '0;
        end else if (PIX_EN) begin
            if (x_q == 11'(H_ACTIVE - 1)) begin
                x_q <= '0;
                y_q <= (y_q == 11'(V_ACTIVE - 1)) ? 11'd0 : y_q + 11'd1;
            end else begin
                x_q <= x_q + 11'd1;
            end
        end
    end

    // Shadow follows every load; active only changes on the last pixel of a frame.
    always_ff @(posedge VGA_CLK or posedge RST_N) begin
        if (RST_N) begin
            sh_bcd_q  <= '0;
            sh_en_q   <= '0;
            act_bcd_q <= '0;
            act_en_q  <= '0;
        end else begin
            if (BCD_LOAD) begin
                sh_bcd_q <= NUMBER_BCD;
                sh_en_q  <= DIGIT_EN;
            end
            if (last_pix) begin
                act_bcd_q <= BCD_LOAD ? NUMBER_BCD : sh_bcd_q;
                act_en_q  <= BCD_LOAD ? DIGIT_EN : sh_en_q;
            end
        end
    end

`ifdef VGA_OVL_BLINK_EN
    // Counter advances with the buffer swap so each phase starts at pixel (0,0).
    always_ff @(posedge VGA_CLK or posedge RST_N) begin
        if (RST_N) begin
            sh_blink_q  <= '0;
            act_blink_q <= '0;
            frame_cnt_q <= '0;
        end else begin
            if (BCD_LOAD) sh_blink_q <= BLINK_MASK;
            if (last_pix) begin
                act_blink_q <= BCD_LOAD ? BLINK_MASK : sh_blink_q;
                frame_cnt_q <= frame_cnt_q + 6'd1;
            end
        end
    end
`endif

    always_comb begin
        blank   = '0;
        leading = (LZB != 0);
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (leading && act_en_q[i] && (act_bcd_q[4*i +: 4] == 4'd0)) blank[i] = 1'b1;
            else                                                         leading  = 1'b0;
        end
    end

    assign px = {1'b0, x_q};
    assign py = {1'b0, y_q};

    always_comb begin
        hit      = 1'b0;
        hit_show = 1'b0;
        hit_bcd  = '0;
        hit_col  = '0;
        hit_row  = '0;
        dx       = '0;
        dy       = py - 12'(POS_Y);
        in_rows  = (py >= 12'(POS_Y)) && (dy < 12'(CELL_H));
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dx = px - cell_x0(i);
            if (in_rows && (px >= cell_x0(i)) && (dx < 12'(CELL_W))) begin
                hit      = 1'b1;
                hit_bcd  = act_bcd_q[4*i +: 4];
                hit_show = act_en_q[i] & ~blank[i];
`ifdef VGA_OVL_BLINK_EN
                if (act_blink_q[i] && frame_cnt_q[5]) hit_show = 1'b0;
`endif
                hit_col  = 3'(dx >> SCALE_LOG2);
                hit_row  = 4'(dy >> SCALE_LOG2);
            end
        end
    end

    always_ff @(posedge VGA_CLK or posedge RST_N) begin
        if (RST_N) begin
            s1_vld_q   <= 1'b0;
            s1_fe_q    <= 1'b0;
            s1_show_q  <= 1'b0;
            s1_glyph_q <= '0;
            s1_row_q   <= '0;
            s1_col_q   <= '0;
            s2_vld_q   <= 1'b0;
            s2_fe_q    <= 1'b0;
            s2_show_q  <= 1'b0;
        end else begin
            s1_vld_q   <= PIX_EN;
            s1_fe_q    <= last_pix;
            s1_show_q  <= PIX_EN & hit & hit_show;
            s1_glyph_q <= bcd_to_glyph(hit_bcd);
            s1_row_q   <= hit_row;
            s1_col_q   <= hit_col;
            s2_vld_q   <= s1_vld_q;
            s2_fe_q    <= s1_fe_q;
            s2_show_q  <= s1_show_q;
        end
    end

    vga_glyph_rom u_rom (
        .VGA_CLK (VGA_CLK),
        .RST_N   (RST_N),
        .glyph   (s1_glyph_q),
        .row     (s1_row_q),
        .col     (s1_col_q),
        .pixel   (rom_bit)
    );

    always_comb begin
        VGA_BUF_RGB = '0;
        if (s2_vld_q) VGA_BUF_RGB = (s2_show_q && rom_bit) ? FG_COLOR : BG_COLOR;
    end

    assign RGB_VLD   = s2_vld_q;
    assign FRAME_END = s2_fe_q;

endmodule

// File: tb/tb_vga_digit_overlay.sv
// Self-checking bench for vga_digit_overlay against a rectangle-based segment font model.
module tb_vga_digit_overlay;

    localparam int H  = 64;
    localparam int V  = 32;
    localparam int ND = 2;
    localparam int S  = 0;
    localparam int GP = 0;
    localparam int PX = 8;
    localparam int PY = 4;
    localparam int LZ = 1;
    localparam logic [23:0] FG = 24'hFFEE00;
    localparam logic [23:0] BG = 24'h123456;

    logic        VGA_CLK = 1'b0;
    logic        RST_N;
    logic        PIX_EN;
    logic [7:0]  NUMBER_BCD;
    logic [1:0]  DIGIT_EN;
    logic        BCD_LOAD;
    logic [23:0] VGA_BUF_RGB;
    logic        RGB_VLD;
    logic        FRAME_END;
`ifdef VGA_OVL_BLINK_EN
    logic [1:0]  BLINK_MASK;
`endif

    vga_digit_overlay #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .NUM_DIGITS (ND),
        .SCALE_LOG2 (S),
        .GAP        (GP),
        .POS_X      (PX),
        .POS_Y      (PY),
        .FG_COLOR   (FG),
        .BG_COLOR   (BG),
        .LZB        (LZ)
    ) dut (
        .VGA_CLK     (VGA_CLK),
        .RST_N       (RST_N),
        .PIX_EN      (PIX_EN),
        .NUMBER_BCD  (NUMBER_BCD),
        .DIGIT_EN    (DIGIT_EN),
`ifdef VGA_OVL_BLINK_EN
        .BLINK_MASK  (BLINK_MASK),
`endif
        .BCD_LOAD    (BCD_LOAD),
        .VGA_BUF_RGB (VGA_BUF_RGB),
        .RGB_VLD     (RGB_VLD),
        .FRAME_END   (FRAME_END)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    // Reference model state
    int          mx, my, mframes;
    logic [7:0]  sh_bcd, act_bcd;
    logic [1:0]  sh_en, act_en, sh_bm, act_bm;
    logic [5:0]  m_fcnt;
    logic [25:0] expq[$];
    int          n_pass, n_total;

    string segs [11] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg",
                         "abc", "abcdefg", "abcdfg", "g"};

    function automatic bit seg_on(byte s, int c, int r);
        case (s)
            "a":     return c >= 1 && c <= 6 && r >= 1 && r <= 2;
            "b":     return c >= 5 && c <= 6 && r >= 1 && r <= 8;
            "c":     return c >= 5 && c <= 6 && r >= 7 && r <= 14;
            "d":     return c >= 1 && c <= 6 && r >= 13 && r <= 14;
            "e":     return c >= 1 && c <= 2 && r >= 7 && r <= 14;
            "f":     return c >= 1 && c <= 2 && r >= 1 && r <= 8;
            "g":     return c >= 1 && c <= 6 && r >= 7 && r <= 8;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit glyph_lit(int g, int c, int r);
        string s = segs[g];
        for (int k = 0; k < s.len(); k++) if (seg_on(s[k], c, r)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [23:0] ref_pixel(int x, int y);
        int w = 8 << S;
        int h = 16 << S;
        int first_sig = -1;
        for (int i = 0; i < ND; i++)
            if (!(act_en[i] && act_bcd[4*i +: 4] == 4'd0)) first_sig = i;
        for (int i = 0; i < ND; i++) begin
            int x0 = PX + (ND - 1 - i) * (w + GP);
            if (x >= x0 && x < x0 + w && y >= PY && y < PY + h) begin
                int v = int'(act_bcd[4*i +: 4]);
                int g = (v > 9) ? 10 : v;
                bit shown = act_en[i] && !(LZ != 0 && i > 0 && i > first_sig)
                            && !(act_bm[i] && m_fcnt[5]);
                if (shown && glyph_lit(g, (x - x0) >> S, (y - PY) >> S)) return FG;
            end
        end
        return BG;
    endfunction

    task automatic model_reset();
        mx = 0; my = 0;
        sh_bcd = '0; act_bcd = '0; sh_en = '0; act_en = '0; sh_bm = '0; act_bm = '0;
        m_fcnt = '0;
        expq.delete();
        expq.push_back(26'd0);
    endtask

    // Drives one cycle and returns the expected output visible after its edge.
    task automatic step(input logic pe, input logic ld, input logic [7:0] bcd,
                        input logic [1:0] en, input logic [1:0] bm, output logic [25:0] e);
        bit last;
        PIX_EN = pe; BCD_LOAD = ld; NUMBER_BCD = bcd; DIGIT_EN = en;
`ifdef VGA_OVL_BLINK_EN
        BLINK_MASK = bm;
`endif
        last = pe && mx == H - 1 && my == V - 1;
        expq.push_back(pe ? {ref_pixel(mx, my), 1'b1, last} : 26'd0);
        if (ld) begin sh_bcd = bcd; sh_en = en; sh_bm = bm; end
        if (pe) begin
            if (last) begin
                act_bcd = sh_bcd; act_en = sh_en; act_bm = sh_bm;
                m_fcnt++; mframes++;
            end
            if (mx == H - 1) begin mx = 0; my = (my == V - 1) ? 0 : my + 1; end
            else mx++;
        end
        @(posedge VGA_CLK); #1;
        e = expq.pop_front();
    endtask

    task automatic test_reset();
        logic [25:0] e;
        RST_N = 1'b1; PIX_EN = 1'b1; BCD_LOAD = 1'b1; NUMBER_BCD = 8'h99; DIGIT_EN = 2'b11;
        repeat (3) @(posedge VGA_CLK);
        #1;
        n_total++;
        if ({VGA_BUF_RGB, RGB_VLD, FRAME_END} !== 26'd0)
            $display("FAIL reset_state: got %h exp 0", {VGA_BUF_RGB, RGB_VLD, FRAME_END});
        else n_pass++;
        BCD_LOAD = 1'b0; PIX_EN = 1'b0; RST_N = 1'b0;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 8'h00, 2'b00, 2'b00, e);
            n_total++;
            if ({VGA_BUF_RGB, RGB_VLD, FRAME_END} !== e)
                $display("FAIL reset_idle: got %h exp %h", {VGA_BUF_RGB, RGB_VLD, FRAME_END}, e);
            else n_pass++;
        end
    endtask

    task automatic test_counter();
        logic [25:0] e;
        int fe_cnt = 0, fe_at = -1;
        for (int k = 0; k < 2050; k++) begin
            step(1'b1, k == 0, 8'h17, 2'b11, 2'b00, e);
            if (FRAME_END === 1'b1) begin fe_cnt++; fe_at = k; end
            n_total++;
            if ({VGA_BUF_RGB, RGB_VLD, FRAME_END} !== e)
                $display("FAIL counter_pix: got %h exp %h", {VGA_BUF_RGB, RGB_VLD, FRAME_END}, e);
            else n_pass++;
        end
        n_total++;
        if (fe_cnt != 1 || fe_at != 2048)
            $display("FAIL frame_end_pulse: got count %0d at %0d exp count 1 at 2048",
                     fe_cnt, fe_at);
        else n_pass++;
        for (int k = 0; k < 4000 && !(mx == 10 && my == 6); k++) begin
            step(1'b1, 1'b0, 8'h00, 2'b00, 2'b00, e);
            n_total++;
            if ({VGA_BUF_RGB, RGB_VLD, FRAME_END} !== e)
                $display("FAIL counter_run: got %h exp %h", {VGA_BUF_RGB, RGB_VLD, FRAME_END}, e);
            else n_pass++;
        end
        for (int k = 0; k < 200; k++) begin
            step(!(k < 5), 1'b0, 8'h00, 2'b00, 2'b00, e);
            n_total++;
            if ({VGA_BUF_RGB, RGB_VLD, FRAME_END} !== e)
                $display("FAIL counter_gap: got %h exp %h", {VGA_BUF_RGB, RGB_VLD, FRAME_END}, e);
            else n_pass++;
        end
    endtask

    task automatic test_render();
        logic [25:0] e;
        int f0 = mframes;
        for (int k = 0; k < 5000 && mframes < f0 + 2; k++) begin
            step(1'b1, k == 0, 8'h42, 2'b11, 2'b00, e);
            n_total++;
            if ({VGA_BUF_RGB, RGB_VLD, FRAME_END} !== e)
                $display("FAIL render_42: got %h exp %h", {VGA_BUF_RGB, RGB_VLD, FRAME_END}, e);
            else n_pass++;
        end
        n_total++;
        if (mframes < f0 + 2) $display("FAIL render_timeout: got %0d frames exp 2", mframes - f0);
        else n_pass++;
    endtask

    task automatic test_tear_free();
        logic [25:0] e;
        int f0;
        for (int k = 0; k < 3000 && my != 10; k++) step(1'b1, 1'b0, 8'h00, 2'b00, 2'b00, e);
        f0 = mframes;
        for (int k = 0; k < 5000 && mframes < f0 + 2; k++) begin
            step(1'b1, k == 0, 8'h31, 2'b11, 2'b00, e);
            n_total++;
            if ({VGA_BUF_RGB, RGB_VLD, FRAME_END} !== e)
                $display("FAIL tear_mid_load: got %h exp %h", {VGA_BUF_RGB, RGB_VLD, FRAME_END}, e);
            else n_pass++;
        end
        f0 = mframes;
        for (int k = 0; k < 5000 && mframes < f0 + 2; k++) begin
            step(1'b1, mx == H - 1 && my == V - 1 && mframes == f0, 8'h96, 2'b10, 2'b00, e);
            n_total++;
            if ({VGA_BUF_RGB, RGB_VLD, FRAME_END} !== e)
                $display("FAIL tear_last_load: got %h exp %h", {VGA_BUF_RGB, RGB_VLD, FRAME_END}, e);
            else n_pass++;
        end
    endtask

    task automatic test_edge_cases();
        logic [25:0] e;
        logic [7:0] vals [5] = '{8'h05, 8'h00, 8'hA0, 8'h00, 8'h70};
        logic [1:0] ens  [5] = '{2'b11, 2'b11, 2'b11, 2'b01, 2'b10};
        for (int v = 0; v <= 5; v++) begin
            int f0 = mframes;
            for (int k = 0; k < 3000 && mframes == f0; k++) begin
                step(1'b1, k == 0 && v < 5, vals[v % 5], ens[v % 5], 2'b00, e);
                n_total++;
                if ({VGA_BUF_RGB, RGB_VLD, FRAME_END} !== e)
                    $display("FAIL edge_%0d: got %h exp %h", v,
                             {VGA_BUF_RGB, RGB_VLD, FRAME_END}, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        logic [25:0] e;
        int f0 = mframes;
        for (int k = 0; k < 12000 && mframes < f0 + 3; k++) begin
            step($urandom_range(0, 9) < 8, $urandom_range(0, 199) == 0, 8'($urandom),
                 2'($urandom), 2'b00, e);
            n_total++;
            if ({VGA_BUF_RGB, RGB_VLD, FRAME_END} !== e)
                $display("FAIL random_pix: got %h exp %h", {VGA_BUF_RGB, RGB_VLD, FRAME_END}, e);
            else n_pass++;
        end
    endtask

`ifdef VGA_OVL_BLINK_EN
    task automatic test_blink();
        logic [25:0] e;
        int f0;
        RST_N = 1'b1; PIX_EN = 1'b0; BCD_LOAD = 1'b0;
        @(posedge VGA_CLK); #1;
        RST_N = 1'b0;
        model_reset();
        f0 = mframes;
        for (int k = 0; k < 70000 && mframes < f0 + 33; k++) begin
            step(1'b1, k == 0, 8'h88, 2'b11, 2'b01, e);
            n_total++;
            if ({VGA_BUF_RGB, RGB_VLD, FRAME_END} !== e)
                $display("FAIL blink_pix: got %h exp %h", {VGA_BUF_RGB, RGB_VLD, FRAME_END}, e);
            else n_pass++;
        end
    endtask
`endif

    task automatic test_reset_mid();
        logic [25:0] e;
        int f0;
        for (int k = 0; k < 3000 && !(mx == 30 && my == 10); k++)
            step(1'b1, 1'b0, 8'h00, 2'b00, 2'b00, e);
        PIX_EN = 1'b1;
        RST_N  = 1'b1;
        #1;
        n_total++;
        if ({VGA_BUF_RGB, RGB_VLD} !== 25'd0)
            $display("FAIL reset_async: got %h exp 0", {VGA_BUF_RGB, RGB_VLD});
        else n_pass++;
        @(posedge VGA_CLK); #1;
        PIX_EN = 1'b0;
        RST_N  = 1'b0;
        model_reset();
        f0 = mframes;
        for (int k = 0; k < 5000 && mframes < f0 + 2; k++) begin
            step(1'b1, k == 0, 8'h42, 2'b11, 2'b00, e);
            n_total++;
            if ({VGA_BUF_RGB, RGB_VLD, FRAME_END} !== e)
                $display("FAIL reset_restart: got %h exp %h", {VGA_BUF_RGB, RGB_VLD, FRAME_END}, e);
            else n_pass++;
        end
    endtask

    initial begin
        n_pass = 0; n_total = 0; mframes = 0;
        RST_N = 1'b1; PIX_EN = 1'b0; BCD_LOAD = 1'b0; NUMBER_BCD = '0; DIGIT_EN = '0;
`ifdef VGA_OVL_BLINK_EN
        BLINK_MASK = '0;
`endif
        test_reset();
        test_counter();
        test_render();
`ifdef VGA_OVL_BLINK_EN
        test_blink();
`else
        test_tear_free();
        test_edge_cases();
        test_random();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
